// File: rtl/pll_drp_pkg.sv
// Shared definitions for the PLLE2 DRP reconfiguration block: FSM state codes, counter
// register map, keep masks, error codes and the divider field encoder.
package pll_drp_pkg;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_CHECK     = 4'd1;
    localparam logic [3:0] S_RD        = 4'd2;
    localparam logic [3:0] S_RD_WAIT   = 4'd3;
    localparam logic [3:0] S_WR        = 4'd4;
    localparam logic [3:0] S_WR_WAIT   = 4'd5;
    localparam logic [3:0] S_VFY       = 4'd6;
    localparam logic [3:0] S_VFY_WAIT  = 4'd7;
    localparam logic [3:0] S_NEXT      = 4'd8;
    localparam logic [3:0] S_WAIT_LOCK = 4'd9;
    localparam logic [3:0] S_DONE      = 4'd10;
    localparam logic [3:0] S_ERR       = 4'd11;

    // CLKOUT0 ClkReg1/ClkReg2, then CLKFBOUT ClkReg1/ClkReg2
    localparam logic [6:0] REG_ADDR [4] = '{7'h08, 7'h09, 7'h14, 7'h15};

    localparam logic [15:0] KEEP_REG1 = 16'hF000;
    localparam logic [15:0] KEEP_REG2 = 16'hFF3F;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_PARAM    = 3'd1;
    localparam logic [2:0] ERR_DRDY     = 3'd2;
    localparam logic [2:0] ERR_LOCK     = 3'd3;
    localparam logic [2:0] ERR_READBACK = 3'd4;

    // Divide-by-1 bypasses the counter: NO_COUNT set, EDGE cleared, high/low forced to 1.
    function automatic logic [15:0] drp_field(input logic is_reg2, input logic [6:0] d);
        logic [5:0] high;
        logic [5:0] low;
        logic       bypass;
        bypass = (d == 7'd1);
        high   = d[6:1];
        low    = 6'(d - {1'b0, d[6:1]});
        if (bypass) begin
            high = 6'd1;
            low  = 6'd1;
        end
        if (is_reg2)
            drp_field = {8'h00, d[0] & ~bypass, bypass, 6'h00};
        else
            drp_field = {4'h0, high, low};
    endfunction

endpackage

// File: rtl/pll_drp_txn.sv
// Single-outstanding DRP read/write engine: launches one DEN pulse per request and
// reports either the returned data or a DRDY timeout.
module pll_drp_txn
    import pll_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [6:0]  addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        timeout,
    output logic [6:0]  drp_addr,
    output logic [15:0] drp_di,
    output logic        drp_den,
    output logic        drp_dwe,
    input  logic [15:0] drp_do,
    input  logic        drp_rdy
);
    localparam int CW = $clog2(DRDY_TIMEOUT + 1);

    logic          pending;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b0;
            cnt      <= '0;
            ack      <= 1'b0;
            timeout  <= 1'b0;
            rdata    <= '0;
            drp_addr <= '0;
            drp_di   <= '0;
            drp_den  <= 1'b0;
            drp_dwe  <= 1'b0;
        end else begin
            drp_den <= 1'b0;
            drp_dwe <= 1'b0;
            ack     <= 1'b0;
            timeout <= 1'b0;
            if (pending) begin
                if (drp_rdy) begin
                    ack     <= 1'b1;
                    rdata   <= drp_do;
                    pending <= 1'b0;
                end else if (cnt == CW'(DRDY_TIMEOUT - 1)) begin
                    timeout <= 1'b1;
                    pending <= 1'b0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (req) begin
                // address/data stay put until the next request, covering the whole DRDY wait
                drp_den  <= 1'b1;
                drp_dwe  <= we;
                drp_addr <= addr;
                drp_di   <= wdata;
                pending  <= 1'b1;
                cnt      <= '0;
            end
        end
    end

endmodule

// File: rtl/pll_drp_reconfig.sv
// PLLE2 dynamic reconfiguration initiator: checks the new CLKOUT0 divide / CLKFBOUT multiply,
// RMWs the four counter registers under PLL reset, then waits for lock. Define
// PLL_DRP_READBACK_EN to add a verify read after every write.
//
// state        | meaning
// IDLE         | waiting for start
// CHECK        | range-check latched parameters
// RD, RD_WAIT  | read current register contents
// WR, WR_WAIT  | write merged value
// VFY,VFY_WAIT | re-read and compare (readback builds only)
// NEXT         | advance register index or release PLL reset
// WAIT_LOCK    | wait for LOCKED, bounded by LOCK_TIMEOUT
// DONE, ERR    | one-cycle success / failure
module pll_drp_reconfig
    import pll_drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic        start,
    input  logic [6:0]  out0_div,
    input  logic [6:0]  fb_mult,
    output logic [6:0]  DADDR,
    output logic [15:0] DI,
    output logic        DEN,
    output logic        DWE,
    input  logic [15:0] DO,
    input  logic        DRDY,
    input  logic        LOCKED,
    output logic        PLL_RST,
    output logic        busy,
    output logic        done,
    output logic [2:0]  err_code
);
    logic [3:0]  state_q, state_d;
    logic [1:0]  idx_q;
    logic [6:0]  out0_q, fb_q, d_sel;
    logic [15:0] rd_q, wr_word, txn_rdata;
    logic [2:0]  err_q, err_d;
    logic        pll_rst_q, pll_rst_d, legal;
    logic        txn_req, txn_we, txn_ack, txn_timeout;
    logic [16:0] timer_q;

    pll_drp_txn #(.DRDY_TIMEOUT(DRDY_TIMEOUT)) u_txn (
        .clk      (CLK100MHZ),
        .rst      (RST),
        .req      (txn_req),
        .we       (txn_we),
        .addr     (REG_ADDR[idx_q]),
        .wdata    (wr_word),
        .ack      (txn_ack),
        .rdata    (txn_rdata),
        .timeout  (txn_timeout),
        .drp_addr (DADDR),
        .drp_di   (DI),
        .drp_den  (DEN),
        .drp_dwe  (DWE),
        .drp_do   (DO),
        .drp_rdy  (DRDY)
    );

    assign d_sel   = idx_q[1] ? fb_q : out0_q;
    assign wr_word = (rd_q & (idx_q[0] ? KEEP_REG2 : KEEP_REG1)) | drp_field(idx_q[0], d_sel);
    assign legal   = (out0_q >= 7'd1) && (out0_q <= 7'd64) && (fb_q >= 7'd2) && (fb_q <= 7'd64);

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        pll_rst_d = pll_rst_q;
        txn_req   = 1'b0;
        txn_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                pll_rst_d = 1'b0;
                if (start) begin
                    err_d   = ERR_NONE;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!legal) begin
                    err_d   = ERR_PARAM;
                    state_d = S_ERR;
                end else begin
                    pll_rst_d = 1'b1;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                txn_req = 1'b1;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (txn_ack) begin
                    state_d = S_WR;
                end else if (txn_timeout) begin
                    err_d   = ERR_DRDY;
                    state_d = S_ERR;
                end
            end
            S_WR: begin
                txn_req = 1'b1;
                txn_we  = 1'b1;
                state_d = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (txn_ack) begin
`ifdef PLL_DRP_READBACK_EN
                    state_d = S_VFY;
`else
                    state_d = S_NEXT;
`endif
                end else if (txn_timeout) begin
                    err_d   = ERR_DRDY;
                    state_d = S_ERR;
                end
            end
`ifdef PLL_DRP_READBACK_EN
            S_VFY: begin
                txn_req = 1'b1;
                state_d = S_VFY_WAIT;
            end
            S_VFY_WAIT: begin
                // rd_q is untouched by the verify read, so wr_word still equals what was written
                if (txn_ack) begin
                    if (txn_rdata == wr_word) begin
                        state_d = S_NEXT;
                    end else begin
                        err_d   = ERR_READBACK;
                        state_d = S_ERR;
                    end
                end else if (txn_timeout) begin
                    err_d   = ERR_DRDY;
                    state_d = S_ERR;
                end
            end
`endif
            S_NEXT: begin
                if (idx_q == 2'd3) begin
                    pll_rst_d = 1'b0;
                    state_d   = S_WAIT_LOCK;
                end else begin
                    state_d = S_RD;
                end
            end
            S_WAIT_LOCK: begin
                if (LOCKED) begin
                    state_d = S_DONE;
                end else if (timer_q == 17'(LOCK_TIMEOUT - 1)) begin
                    err_d   = ERR_LOCK;
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_ERR)
            pll_rst_d = 1'b0;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            out0_q    <= '0;
            fb_q      <= '0;
            rd_q      <= '0;
            err_q     <= ERR_NONE;
            pll_rst_q <= 1'b1;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            pll_rst_q <= pll_rst_d;
            if (state_q == S_IDLE && start) begin
                out0_q <= out0_div;
                fb_q   <= fb_mult;
            end
            if (state_q == S_CHECK)
                idx_q <= '0;
            else if (state_q == S_NEXT && idx_q != 2'd3)
                idx_q <= idx_q + 1'b1;
            if (state_q == S_RD_WAIT && txn_ack)
                rd_q <= txn_rdata;
            if (state_d != state_q)
                timer_q <= '0;
            else if (timer_q != '1)
                timer_q <= timer_q + 1'b1;
        end
    end

    assign PLL_RST  = pll_rst_q;
    assign err_code = err_q;
    assign done     = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Randomized bench for pll_drp_reconfig: DRP responder with a register array, a PLL lock
// model, and an arithmetic reference for the expected counter register writes.
module tb_pll_drp_reconfig;

    logic        CLK100MHZ = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  out0_div = '0;
    logic [6:0]  fb_mult = '0;
    logic [6:0]  DADDR;
    logic [15:0] DI;
    logic        DEN, DWE;
    logic [15:0] DO = '0;
    logic        DRDY = 1'b0;
    logic        LOCKED = 1'b0;
    logic        PLL_RST, busy, done;
    logic [2:0]  err_code;

    always #5 CLK100MHZ = ~CLK100MHZ;

    pll_drp_reconfig dut (
        .CLK100MHZ (CLK100MHZ),
        .RST       (RST),
        .start     (start),
        .out0_div  (out0_div),
        .fb_mult   (fb_mult),
        .DADDR     (DADDR),
        .DI        (DI),
        .DEN       (DEN),
        .DWE       (DWE),
        .DO        (DO),
        .DRDY      (DRDY),
        .LOCKED    (LOCKED),
        .PLL_RST   (PLL_RST),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DRP responder: DRDY resp_lat cycles after DEN, register contents held in mem
    logic [15:0] mem    [128];
    logic [15:0] wr_val [128];
    int          resp_lat = 3;
    bit          resp_dead = 1'b0;
    int          resp_cnt = 0;
    logic [6:0]  resp_addr = '0;
    int          den_cnt = 0, wr_cnt = 0, overlap_cnt = 0;

    always @(negedge CLK100MHZ) begin
        DRDY = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                DRDY = 1'b1;
                DO   = mem[resp_addr];
            end
        end
        if (DEN) begin
            den_cnt++;
            if (resp_cnt > 0) overlap_cnt++;
            resp_addr = DADDR;
            if (DWE) begin
                mem[DADDR]    = DI;
                wr_val[DADDR] = DI;
                wr_cnt++;
            end
            if (!resp_dead) resp_cnt = resp_lat;
        end
    end

    // PLL lock model: LOCKED rises lock_delay cycles after PLL_RST is released
    bit lock_en = 1'b1;
    int lock_delay = 4;
    int lock_cnt = 0;

    always @(negedge CLK100MHZ) begin
        if (PLL_RST || !lock_en) begin
            lock_cnt = 0;
            LOCKED   = 1'b0;
        end else if (lock_cnt < lock_delay) begin
            lock_cnt++;
        end else begin
            LOCKED = 1'b1;
        end
    end

    int addr_tab [4] = '{8, 9, 20, 21};

    function automatic logic [15:0] exp_word(input int i, input logic [15:0] pre, input int d);
        int hi, lo;
        logic [15:0] f, m;
        if (i % 2 == 0) begin
            m = 16'hF000;
            if (d == 1) begin hi = 1; lo = 1; end
            else begin hi = d / 2; lo = d - hi; end
            f = 16'(hi * 64 + lo);
        end else begin
            m = 16'hFF3F;
            f = (d == 1) ? 16'd64 : 16'((d % 2) * 128);
        end
        return (pre & m) | f;
    endfunction

    task automatic run_op(input int d0, input int fm, input int budget, input string tag,
                          output int cyc);
        logic [15:0] pre [4];
        int  exp_err;
        bit  rst_seen;
        bit  legal;
        legal = (d0 >= 1 && d0 <= 64 && fm >= 2 && fm <= 64);
        exp_err = !legal ? 1 : resp_dead ? 2 : !lock_en ? 3 : 0;
        @(posedge CLK100MHZ);
        den_cnt = 0; wr_cnt = 0; overlap_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            pre[i] = mem[addr_tab[i]];
            wr_val[addr_tab[i]] = 'x;
        end
        @(negedge CLK100MHZ);
        out0_div = 7'(d0);
        fb_mult  = 7'(fm);
        start    = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        cyc = 0;
        rst_seen = 1'b0;
        while (busy && cyc < budget) begin
            @(negedge CLK100MHZ);
            cyc++;
            if (PLL_RST) rst_seen = 1'b1;
        end
        check({tag, "_bound"}, busy, 0);
        check({tag, "_done"}, done, (exp_err == 0));
        check({tag, "_err"}, err_code, exp_err);
        check({tag, "_pllrst"}, PLL_RST, 0);
        if (exp_err == 1) begin
            check({tag, "_no_den"}, den_cnt, 0);
            check({tag, "_rst_never"}, rst_seen, 0);
        end
        if (exp_err == 0) begin
            check({tag, "_den_cnt"}, den_cnt, 8);
            check({tag, "_wr_cnt"}, wr_cnt, 4);
            check({tag, "_overlap"}, overlap_cnt, 0);
            check({tag, "_rst_seen"}, rst_seen, 1);
            for (int i = 0; i < 4; i++)
                check($sformatf("%s_reg%02h", tag, addr_tab[i]), wr_val[addr_tab[i]],
                      exp_word(i, pre[i], (i < 2) ? d0 : fm));
        end
        @(negedge CLK100MHZ);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_err_sticky"}, err_code, exp_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int d0, fm;
        logic [15:0] tmp;
        for (int a = 0; a < 128; a++) mem[a] = 16'($urandom);

        repeat (2) @(negedge CLK100MHZ);
        check("rst_daddr", DADDR, 0);
        check("rst_di", DI, 0);
        check("rst_den", DEN, 0);
        check("rst_dwe", DWE, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        check("rst_pllrst", PLL_RST, 1);
        RST = 1'b0;
        repeat (2) @(negedge CLK100MHZ);
        check("pllrst_release", PLL_RST, 0);

        mem[8] = 16'h1041;
        run_op(10, 10, 2000, "t1", cyc);
        check("t1_reg08_lit", wr_val[8], 16'h1145);

        mem[9] = 16'h0000;
        run_op(7, 33, 2000, "t2", cyc);
        tmp = wr_val[8] & 16'h0FFF;
        check("t2_reg08_field", tmp, 16'h00C4);
        check("t2_reg09_lit", wr_val[9], 16'h0080);

        mem[9] = 16'hFFFF;
        run_op(1, 64, 2000, "t3", cyc);
        tmp = wr_val[8] & 16'h0FFF;
        check("t3_reg08_field", tmp, 16'h0041);
        check("t3_reg09_lit", wr_val[9], 16'hFF7F);

        run_op(10, 1, 2000, "t4", cyc);

        resp_dead = 1'b1;
        run_op(10, 10, 500, "t5", cyc);
        resp_dead = 1'b0;
        check("t5_window", (cyc >= 64 && cyc <= 72), 1);

        // reset while the first read is outstanding; its DRDY later lands in IDLE
        @(negedge CLK100MHZ);
        out0_div = 7'd20; fb_mult = 7'd20; start = 1'b1;
        @(negedge CLK100MHZ);
        start = 1'b0;
        cyc = 0;
        while (!(DEN && !DWE) && cyc < 50) begin
            @(negedge CLK100MHZ);
            cyc++;
        end
        check("t6_rd_den", DEN, 1);
        RST = 1'b1;
        @(negedge CLK100MHZ);
        check("t6_daddr", DADDR, 0);
        check("t6_di", DI, 0);
        check("t6_den", DEN, 0);
        check("t6_dwe", DWE, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_err", err_code, 0);
        check("t6_pllrst", PLL_RST, 1);
        RST = 1'b0;
        repeat (6) @(negedge CLK100MHZ);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_err", err_code, 0);
        run_op(20, 20, 2000, "t6_after", cyc);

        for (int k = 0; k < 12; k++) begin
            int mode;
            mode = $urandom_range(0, 5);
            d0 = $urandom_range(1, 64);
            fm = $urandom_range(2, 64);
            if (mode == 0) fm = $urandom_range(0, 1) ? $urandom_range(0, 1) : $urandom_range(65, 127);
            if (mode == 1) d0 = $urandom_range(0, 1) ? 0 : $urandom_range(65, 127);
            resp_lat   = $urandom_range(1, 5);
            lock_delay = $urandom_range(0, 20);
            for (int i = 0; i < 4; i++) mem[addr_tab[i]] = 16'($urandom);
            run_op(d0, fm, 2000, $sformatf("rnd%0d", k), cyc);
        end

        resp_lat = 3;
        lock_en  = 1'b0;
        run_op(12, 30, 70000, "t7", cyc);
        lock_en = 1'b1;
        check("t7_window", (cyc >= 65536 && cyc <= 65536 + 150), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
